dmem_rmw_port: RTL and testbench

Data-memory responder that executes the core's load/store requests, encoded as the one-hot MemSrc vector {memb, memh, lw, membu, memhu}, against a word-wide single-port SRAM that has no byte enables. Sub-word stores (sb/sh) are performed as read-modify-write sequences. Loads return lane-extracted, sign- or zero-extended data. The block sits between the core's memory stage and the data SRAM and stalls the core through a valid/ready handshake.

---
 rtl/dmem_rmw_port_pkg.sv | 30 +++
 rtl/dmem_rmw_port_if.sv | 33 +++
 rtl/dmem_rmw_port_lane_extract.sv | 22 ++
 rtl/dmem_rmw_port.sv | 139 +++++++++++++
 tb/tb_dmem_rmw_port.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_rmw_port_pkg.sv
// Shared definitions for the data-memory read-modify-write port:
// MemSrc bit positions, FSM states, per-class latencies and a one-hot helper.
package mem_pkg;

    localparam int MEMB  = 4;
    localparam int MEMH  = 3;
    localparam int LW    = 2;
    localparam int MEMBU = 1;
    localparam int MEMHU = 0;

    // Cycles from the accept edge to the rsp_valid cycle.
    localparam int LAT_ERR        = 1;
    localparam int LAT_WORD_ST    = 2;
    localparam int LAT_LOAD       = 3;
    localparam int LAT_SUBWORD_ST = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_MERGE_WR,
        ST_WR,
        ST_RESP
    } state_e;

    function automatic logic is_onehot5(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

endpackage

// File: rtl/dmem_rmw_port_if.sv
// Core request/response channel plus the word-wide SRAM port of dmem_rmw_port.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// rsp_valid is a single-cycle pulse with no back-pressure.
interface dmem_rmw_port_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [4:0]        req_memsrc;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              sram_ce;
    logic              sram_we;
    logic [ADDR_W-3:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    modport slave (
        input  req_valid, req_we, req_memsrc, req_addr, req_wdata, sram_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               sram_ce, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output req_valid, req_we, req_memsrc, req_addr, req_wdata, sram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               sram_ce, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/dmem_rmw_port_lane_extract.sv
// Picks the addressed byte/half out of an SRAM word and sign- or zero-extends it.
module lane_extract
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [4:0]  memsrc_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{lane_i, 3'b000} +: 8];
        half_sel = word_i[{lane_i[1], 4'b0000} +: 16];
        data_o   = word_i;
        if (memsrc_i[MEMB])       data_o = {{24{byte_sel[7]}}, byte_sel};
        else if (memsrc_i[MEMBU]) data_o = {24'h0, byte_sel};
        else if (memsrc_i[MEMH])  data_o = {{16{half_sel[15]}}, half_sel};
        else if (memsrc_i[MEMHU]) data_o = {16'h0, half_sel};
    end
endmodule

// File: rtl/dmem_rmw_port.sv
// Load/store responder for a byte-enable-less word SRAM; sub-word stores are
// done as read-modify-write, loads return lane-extracted extended data.
module dmem_rmw_port
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_rmw_port_if.slave bus,
    output state_e         dbg_state_o
);
    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [4:0]        memsrc_q, memsrc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;
    logic              accept, req_err;
    logic [31:0]       load_data, merged;
    logic              ce, wen, rvalid, rdy;
    logic [31:0]       sram_wdata_c;

    assign accept  = bus.req_valid && (state_q == ST_IDLE);
    assign req_err = !is_onehot5(bus.req_memsrc)
                  || (bus.req_we && (bus.req_memsrc[MEMBU] || bus.req_memsrc[MEMHU]))
                  || ((bus.req_memsrc[MEMH] || bus.req_memsrc[MEMHU]) && bus.req_addr[0])
                  || (bus.req_memsrc[LW] && (bus.req_addr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)                                 state_d = ST_RESP;
                    else if (bus.req_we && bus.req_memsrc[LW])   state_d = ST_WR;
                    else                                         state_d = ST_RD;
                end
            end
            ST_RD:       state_d = ST_WAIT;
            ST_WAIT:     state_d = we_q ? ST_MERGE_WR : ST_RESP;
            ST_MERGE_WR: state_d = ST_RESP;
            ST_WR:       state_d = ST_RESP;
            ST_RESP:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ce           = 1'b0;
        wen          = 1'b0;
        rvalid       = 1'b0;
        rdy          = 1'b0;
        sram_wdata_c = wdata_q;
        case (state_q)
            ST_IDLE:     rdy = 1'b1;
            ST_RD:       ce  = 1'b1;
            ST_MERGE_WR: begin
                ce           = 1'b1;
                wen          = 1'b1;
                sram_wdata_c = data_q;
            end
            ST_WR: begin
                ce  = 1'b1;
                wen = 1'b1;
            end
            ST_RESP:     rvalid = 1'b1;
            default:     ;
        endcase
    end

    lane_extract u_lane_extract (
        .word_i   (bus.sram_rdata),
        .lane_i   (addr_q[1:0]),
        .memsrc_i (memsrc_q),
        .data_o   (load_data)
    );

    // Only the addressed lane is replaced; the rest of the word comes from the read.
    always_comb begin
        merged = bus.sram_rdata;
        if (memsrc_q[MEMB])      merged[{addr_q[1:0], 3'b000} +: 8]   = wdata_q[7:0];
        else if (memsrc_q[MEMH]) merged[{addr_q[1], 4'b0000} +: 16]   = wdata_q[15:0];
    end

    always_comb begin
        we_d     = we_q;
        memsrc_d = memsrc_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        data_d   = data_q;
        if (accept) begin
            we_d     = bus.req_we;
            memsrc_d = bus.req_memsrc;
            addr_d   = bus.req_addr;
            wdata_d  = bus.req_wdata;
            err_d    = req_err;
            data_d   = 32'h0;
        end else if (state_q == ST_WAIT) begin
            data_d = we_q ? merged : load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            memsrc_q <= 5'h0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            err_q    <= 1'b0;
            data_q   <= 32'h0;
        end else begin
            we_q     <= we_d;
            memsrc_q <= memsrc_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            data_q   <= data_d;
        end
    end

    // Strobes are gated by reset so an abandoned RMW can never reach the SRAM.
    assign bus.req_ready  = rdy;
    assign bus.sram_ce    = ce & rst_n;
    assign bus.sram_we    = wen & rst_n;
    assign bus.rsp_valid  = rvalid & rst_n;
    assign bus.rsp_rdata  = (rvalid && !we_q && !err_q) ? data_q : 32'h0;
    assign bus.rsp_err    = rvalid & err_q;
    assign bus.sram_addr  = addr_q[ADDR_W-1:2];
    assign bus.sram_wdata = sram_wdata_c;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_dmem_rmw_port.sv
// Scoreboard bench for dmem_rmw_port: directed plan, reset aborts, then random traffic
// checked against a byte-level memory model.
module tb_dmem_rmw_port;
    import mem_pkg::*;

    localparam int ADDR_W = 32;
    localparam int EW     = 56;  // {acc[15:0], rdata[31:0], err, lat[2:0], nrd[1:0], nwr[1:0]}

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_rmw_port_if #(.ADDR_W(ADDR_W)) bus ();
    state_e dbg_state;

    dmem_rmw_port #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- SRAM model ----------------
    logic [31:0] sram_mem [0:63] = '{default: 32'h0};
    int unsigned rd_tot = 0;
    int unsigned wr_tot = 0;
    always @(posedge clk) begin
        if (bus.sram_ce) begin
            if (bus.sram_we) begin
                sram_mem[bus.sram_addr[5:0]] <= bus.sram_wdata;
                wr_tot <= wr_tot + 1;
            end else begin
                bus.sram_rdata <= sram_mem[bus.sram_addr[5:0]];
                rd_tot <= rd_tot + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [31:0] ref_mem [0:63] = '{default: 32'h0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural reference: memory viewed as bytes, results from the load/store rules.
    task automatic model(input logic we, input logic [4:0] ms, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [15:0] acc);
        int          idx, k, hk, lat, nrd, nwr;
        logic [31:0] w, b, h, rd;
        logic        err;
        idx = int'(addr[7:2]);
        k   = int'(addr[1:0]);
        hk  = int'(addr[1]);
        w   = ref_mem[idx];
        b   = (w >> (8 * k)) & 32'hFF;
        h   = (w >> (16 * hk)) & 32'hFFFF;
        rd  = 32'h0;
        err = ($countones(ms) != 1)
           || (we && (ms[MEMBU] || ms[MEMHU]))
           || ((ms[MEMH] || ms[MEMHU]) && addr[0])
           || (ms[LW] && (addr[1:0] != 2'b00));
        if (err) begin
            lat = LAT_ERR; nrd = 0; nwr = 0;
        end else if (we) begin
            nwr = 1;
            if (ms[LW]) begin
                lat = LAT_WORD_ST; nrd = 0;
                ref_mem[idx] = wd;
            end else if (ms[MEMB]) begin
                lat = LAT_SUBWORD_ST; nrd = 1;
                ref_mem[idx] = (w & ~(32'hFF << (8 * k))) | ((wd & 32'hFF) << (8 * k));
            end else begin
                lat = LAT_SUBWORD_ST; nrd = 1;
                ref_mem[idx] = (w & ~(32'hFFFF << (16 * hk))) | ((wd & 32'hFFFF) << (16 * hk));
            end
        end else begin
            lat = LAT_LOAD; nrd = 1; nwr = 0;
            if (ms[LW])         rd = w;
            else if (ms[MEMB])  rd = (b >= 128)   ? (b | 32'hFFFF_FF00) : b;
            else if (ms[MEMBU]) rd = b;
            else if (ms[MEMH])  rd = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            else                rd = h;
        end
        exp_q.push_back({acc, rd, err, 3'(lat), 2'(nrd), 2'(nwr)});
    endtask

    // ---------------- monitor ----------------
    int unsigned   rd_mark = 0;
    int unsigned   wr_mark = 0;
    logic [EW-1:0] e;
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_mark = rd_tot;
            wr_mark = wr_tot;
        end else if (bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_cycle",   32'(cyc), 32'(e[55:40]) + 32'(e[6:4]));
                chk("rsp_rdata",   bus.rsp_rdata, e[39:8]);
                chk("rsp_err",     {31'h0, bus.rsp_err}, {31'h0, e[7]});
                chk("sram_reads",  rd_tot - rd_mark, {30'h0, e[3:2]});
                chk("sram_writes", wr_tot - wr_mark, {30'h0, e[1:0]});
            end
            rd_mark = rd_tot;
            wr_mark = wr_tot;
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic we, input logic [4:0] ms, input logic [31:0] addr,
                         input logic [31:0] wd, input bit expect_rsp,
                         output int acc, output int waited);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_memsrc = ms;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        waited = 0;
        acc    = 0;
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=0 for %0d cycles expected 1", waited);
            bus.req_valid = 1'b0;
            return;
        end
        acc = int'(cyc);
        if (expect_rsp) model(we, ms, addr, wd, 16'(cyc));
        @(negedge clk);
        // Scramble inputs after the accept so only latched values can matter.
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom_range(0, 1));
        bus.req_memsrc = 5'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
    endtask

    task automatic abort_sb(input int state_offset, input string tag);
        int          a, wt;
        int unsigned wr0;
        wr0 = wr_tot;
        issue(1'b1, 5'b10000, 32'h13, 32'h5555_5533, 1'b0, a, wt);
        repeat (state_offset - 1) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, "_ready_after_reset"}, {31'h0, bus.req_ready}, 32'h1);
        chk({tag, "_no_write"}, wr_tot - wr0, 32'h0);
    endtask

    task automatic go(input logic we, input logic [4:0] ms, input logic [31:0] addr,
                      input logic [31:0] wd);
        int a, wt;
        issue(we, ms, addr, wd, 1'b1, a, wt);
    endtask

    int a0, a1, a2, wt;
    logic [4:0] rms;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_memsrc = 5'h0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready",  {31'h0, bus.req_ready}, 32'h1);
        chk("rst_rsp_valid",  {31'h0, bus.rsp_valid}, 32'h0);
        chk("rst_rsp_rdata",  bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err",    {31'h0, bus.rsp_err}, 32'h0);
        chk("rst_sram_ce",    {31'h0, bus.sram_ce}, 32'h0);
        chk("rst_sram_we",    {31'h0, bus.sram_we}, 32'h0);
        chk("rst_sram_addr",  {2'b00, bus.sram_addr}, 32'h0);
        chk("rst_sram_wdata", bus.sram_wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Preload, then every load flavour on the preloaded word.
        go(1'b1, 5'b00100, 32'h10, 32'h8081_7F02);
        go(1'b0, 5'b10000, 32'h11, 32'h0);
        go(1'b0, 5'b10000, 32'h12, 32'h0);
        go(1'b0, 5'b00010, 32'h12, 32'h0);
        go(1'b0, 5'b01000, 32'h12, 32'h0);
        go(1'b0, 5'b00001, 32'h12, 32'h0);
        go(1'b0, 5'b00100, 32'h10, 32'h0);
        // Sub-word stores
        go(1'b1, 5'b10000, 32'h13, 32'h1234_56AA);
        go(1'b0, 5'b00100, 32'h10, 32'h0);
        go(1'b1, 5'b00100, 32'h10, 32'h8081_7F02);
        go(1'b1, 5'b01000, 32'h12, 32'h0000_BEEF);
        go(1'b0, 5'b00100, 32'h10, 32'h0);
        go(1'b1, 5'b00100, 32'h14, 32'hDEAD_BEEF);
        go(1'b0, 5'b00100, 32'h14, 32'h0);
        // Rejected requests
        go(1'b1, 5'b01000, 32'h11, 32'h0);
        go(1'b1, 5'b00010, 32'h10, 32'h0);
        go(1'b0, 5'b00110, 32'h10, 32'h0);
        go(1'b0, 5'b00100, 32'h12, 32'h0);
        go(1'b0, 5'b00001, 32'h13, 32'h0);
        go(1'b0, 5'b00000, 32'h10, 32'h0);

        // req_valid held across three loads
        issue(1'b0, 5'b00100, 32'h10, 32'h0, 1'b1, a0, wt);
        issue(1'b0, 5'b10000, 32'h11, 32'h0, 1'b1, a1, wt);
        chk("b2b_gap1", 32'(a1 - a0), 32'd4);
        chk("b2b_ready_low1", 32'(wt), 32'd3);
        issue(1'b0, 5'b00001, 32'h12, 32'h0, 1'b1, a2, wt);
        chk("b2b_gap2", 32'(a2 - a1), 32'd4);
        chk("b2b_ready_low2", 32'(wt), 32'd3);
        repeat (5) @(negedge clk);

        // Reset in WAIT, then in the MERGE_WR cycle; the word must survive both.
        abort_sb(2, "abort_wait");
        go(1'b0, 5'b00100, 32'h10, 32'h0);
        abort_sb(3, "abort_merge");
        go(1'b0, 5'b00100, 32'h10, 32'h0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) < 8) rms = 5'(1 << $urandom_range(0, 4));
            else                          rms = 5'($urandom_range(0, 31));
            go(1'($urandom_range(0, 1)), rms, 32'h40 + 32'($urandom_range(0, 63)), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
